// File: rtl/register_readout.sv
// register_readout: snapshots NREG words on start and streams them out index 0 first over valid/ready.
// First word is valid the cycle after start; the offered word holds stable while out_ready is low.
module register_readout #(
  parameter  int N    = 8,
  parameter  int NREG = 4,
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREG*N-1:0] regs,
  input  logic            start,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NREG*N-1:0]   r_snap;
  logic [IW-1:0]       r_index;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [IW-1:0]       w_index_nxt;
  logic                w_valid_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_capture;
  logic                w_xfer;
  logic                w_at_last;
  logic [N-1:0]        w_data;

  assign w_xfer    = r_valid && out_ready;
  assign w_at_last = (r_index == IW'(NREG - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_index_nxt = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (w_at_last) begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + IW'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_snap <= regs;
      end
    end
  end

  // Word select always reads the frozen snapshot, never the live regs.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_index == IW'(i)) begin
        w_data = r_snap[i*N +: N];
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = w_data;
  assign out_index = r_index;
  assign out_last  = r_valid && w_at_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
